// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package pc_sequencer_pkg;

    // Fetch/instruction address type.
    typedef logic [31:0] pc_t;

    // Fetch FSM: present request, wait for response, hold for decode.
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    localparam pc_t         DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [15:0] KILL_COUNT_MAX   = 16'hFFFF;
    localparam pc_t         PC_STEP          = 32'h0000_0004;

    // Force an address onto a word boundary.
    function automatic pc_t align_pc(input pc_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_sequencer.sv
// Instruction fetch sequencer: one outstanding request to instruction memory,
// a single-entry hand-off to decode, and redirect handling that discards the
// in-flight or held fetch and counts the discards in a saturating counter.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter pc_t RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [15:0] kill_count
);

    state_e      state_q, state_d;
    pc_t         fetch_pc_q, fetch_pc_d;
    logic        kill_q, kill_d;
    logic [15:0] kill_count_q, kill_count_d;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] inst_data_q, inst_data_d;
    pc_t         inst_pc_q, inst_pc_d;
    logic        pc_inc_s;
    logic        kill_inc_s;

    // Next-state, capture and kill bookkeeping for the fetch FSM.
    always_comb begin
        state_d     = state_q;
        kill_d      = kill_q;
        inst_data_d = inst_data_q;
        inst_pc_d   = inst_pc_q;
        pc_inc_s    = 1'b0;
        kill_inc_s  = 1'b0;

        case (state_q)
            ST_FETCH: begin
                if (imem_req_ready) begin
                    // A redirect accepted alongside the request poisons its response.
                    state_d = ST_WAIT;
                    kill_d  = redirect_valid;
                end else begin
                    state_d = ST_FETCH;
                    kill_d  = kill_q;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    if (kill_q || redirect_valid) begin
                        // Stale response: drop it and go fetch the new path.
                        state_d    = ST_FETCH;
                        kill_d     = 1'b0;
                        kill_inc_s = 1'b1;
                    end else begin
                        state_d     = ST_HOLD;
                        inst_data_d = imem_rsp_data;
                        inst_pc_d   = fetch_pc_q;
                        pc_inc_s    = 1'b1;
                    end
                end else if (redirect_valid) begin
                    // Request still outstanding; stay until it returns, then drop it.
                    kill_d = 1'b1;
                end else begin
                    kill_d = kill_q;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    // Redirect wins over a same-cycle decode acceptance.
                    state_d    = ST_FETCH;
                    kill_inc_s = 1'b1;
                end else if (inst_ready) begin
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_FETCH;
                kill_d  = 1'b0;
            end
        endcase

        if (redirect_valid) begin
            fetch_pc_d = align_pc(redirect_target);
        end else if (pc_inc_s) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end else begin
            fetch_pc_d = fetch_pc_q;
        end

        if (kill_inc_s && (kill_count_q != KILL_COUNT_MAX)) begin
            kill_count_d = kill_count_q + 16'd1;
        end else begin
            kill_count_d = kill_count_q;
        end

        inst_valid_d = (state_d == ST_HOLD);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FETCH;
            fetch_pc_q   <= RESET_PC;
            kill_q       <= 1'b0;
            kill_count_q <= 16'h0000;
            inst_valid_q <= 1'b0;
            inst_data_q  <= 32'h0000_0000;
            inst_pc_q    <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            kill_q       <= kill_d;
            kill_count_q <= kill_count_d;
            inst_valid_q <= inst_valid_d;
            inst_data_q  <= inst_data_d;
            inst_pc_q    <= inst_pc_d;
        end
    end

    // Request is suppressed while reset is held so memory never sees a fetch then.
    assign imem_req_valid = (state_q == ST_FETCH) && !rst;
    assign imem_req_addr  = fetch_pc_q;
    assign inst_valid     = inst_valid_q;
    assign inst_data      = inst_data_q;
    assign inst_pc        = inst_pc_q;
    assign kill_count     = kill_count_q;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 imem_req_valid  output  1  fetch request presented to instruction memory.
REQ-005 imem_req_ready  input  1  memory accepts request this cycle.
REQ-006 imem_req_addr  output  32  word-aligned fetch address.
REQ-007 imem_rsp_valid  input  1  fetch data returned this cycle.
REQ-008 imem_rsp_data  input  32  returned instruction word.
REQ-009 inst_valid  output  1  instruction offered to decode.
REQ-010 inst_ready  input  1  decode accepts the offered instruction.
REQ-011 inst_data  output  32  offered instruction word.
REQ-012 inst_pc  output  32  address of the offered instruction.
REQ-013 redirect_valid  input  1  taken branch/jump (NextPCSrc qualified by an executing instruction).
REQ-014 redirect_target  input  32  branch/jump target address.
REQ-015 kill_count  output  16  saturating count of discarded fetches.

Function
REQ-016 The block SHALL implement FSM states FETCH, WAIT, HOLD, with at most one outstanding memory request.
REQ-017 FETCH: imem_req_valid=1, imem_req_addr=fetch_pc; on imem_req_ready go to WAIT.
REQ-018 WAIT: imem_req_valid=0; on imem_rsp_valid capture data, set inst_pc=fetch_pc, fetch_pc+=4 (mod 2^32), go to HOLD.
REQ-019 HOLD: inst_valid=1 with stable inst_data/inst_pc; on inst_ready go to FETCH; FETCH is entered on the next cycle (no same-cycle bypass).
REQ-020 Redirect SHALL load fetch_pc with {redirect_target[31:2],2'b00} in any state, taking priority over sequential increment.
REQ-021 Redirect in FETCH without imem_req_ready: stay FETCH; the new address is presented the next cycle.
REQ-022 Redirect in FETCH with imem_req_ready same cycle: go WAIT with kill flag set.
REQ-023 Redirect in WAIT: set kill flag; a response arriving the same cycle as the redirect is discarded and counted; go FETCH.
REQ-024 WAIT with kill flag set: the next imem_rsp_valid SHALL be discarded (never offered to decode), kill flag cleared, kill_count incremented, then FETCH.
REQ-025 Redirect in HOLD: drop the held instruction (inst_valid=0 next cycle even if inst_ready was high the same cycle), increment kill_count, go FETCH.
REQ-026 kill_count SHALL saturate at 16'hFFFF and never wrap.
REQ-027 imem_req_addr and imem_req_valid SHALL stay stable while waiting for imem_req_ready unless a redirect occurs.
REQ-028 Responses received outside WAIT SHALL be ignored.

Reset
REQ-029 While rst=1: state=FETCH, fetch_pc=RESET_PC, kill flag=0, kill_count=0, inst_valid=0, inst_data=0, inst_pc=0, and imem_req_valid=0 during the reset cycle.
REQ-030 The first cycle after rst deasserts SHALL present imem_req_valid=1, imem_req_addr=RESET_PC.
REQ-031 Reset asserted mid-transaction SHALL abandon any outstanding request; a late response after reset SHALL be ignored (REQ-028).

Structure
REQ-032 Shared package SHALL hold the FSM state enum, the 32-bit PC type and the default RESET_PC constant.
REQ-033 The block SHALL be a single module with no sub-modules; the saturating counter is inline.

Verification
REQ-034 Reset with RESET_PC=0, ready/rsp one cycle later with data 0x00000013 -> inst_valid with inst_pc=0, next request addr=0x4.
REQ-035 imem_req_ready held low 5 cycles -> imem_req_addr stable at same value all 5 cycles, no state change.
REQ-036 Redirect to 0x0000_0102 while in WAIT, then response 0xDEADBEEF -> not offered, kill_count=1, next request addr=0x100.
REQ-037 Redirect in HOLD with inst_ready=1 same cycle -> instruction dropped, kill_count increments, next request addr=target.
REQ-038 fetch_pc=0xFFFF_FFFC fetched -> next request addr=0x0000_0000.
REQ-039 Force 65537 kills -> kill_count reads 0xFFFF.
